// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes RV32I fields into ALU ctrl/operands plus branch hints (ALU_ISSUE_FORWARD_EN adds capture-time forwarding).
// Latency 1 cycle; valid/ready with a 2-entry skid, so back-pressure never drops or reorders entries.
module alu_issue_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_BITS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [DATA_WIDTH-1:0] rs2_data,
  input  logic [DATA_WIDTH-1:0] imm,
  input  logic [DATA_WIDTH-1:0] pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_BITS-1:0]  alu_ctrl,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic                  br,
  output logic                  br_inv,
  output logic                  illegal
`ifdef ALU_ISSUE_FORWARD_EN
  ,
  input  logic [4:0]            rs1_addr,
  input  logic [4:0]            rs2_addr,
  input  logic                  fwd_we,
  input  logic [4:0]            fwd_rd,
  input  logic [DATA_WIDTH-1:0] fwd_data
`endif
);

  localparam logic [CTRL_BITS-1:0] ALU_AND  = CTRL_BITS'(4'b0000);
  localparam logic [CTRL_BITS-1:0] ALU_XOR  = CTRL_BITS'(4'b0001);
  localparam logic [CTRL_BITS-1:0] ALU_ADD  = CTRL_BITS'(4'b0010);
  localparam logic [CTRL_BITS-1:0] ALU_OR   = CTRL_BITS'(4'b0011);
  localparam logic [CTRL_BITS-1:0] ALU_SGE  = CTRL_BITS'(4'b0101);
  localparam logic [CTRL_BITS-1:0] ALU_SUB  = CTRL_BITS'(4'b0110);
  localparam logic [CTRL_BITS-1:0] ALU_SLT  = CTRL_BITS'(4'b0111);
  localparam logic [CTRL_BITS-1:0] ALU_SLTU = CTRL_BITS'(4'b1111);
  localparam logic [CTRL_BITS-1:0] ALU_NOP  = CTRL_BITS'(4'b1000);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [CTRL_BITS-1:0]  ctrl;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic                  br;
    logic                  br_inv;
    logic                  illegal;
  } payload_t;

  logic [DATA_WIDTH-1:0] rs1_val;
  logic [DATA_WIDTH-1:0] rs2_val;

`ifdef ALU_ISSUE_FORWARD_EN
  // Decode only routes rs1/rs2 where they are real sources, so forwarding is naturally scoped.
  assign rs1_val = (fwd_we && (fwd_rd != 5'd0) && (fwd_rd == rs1_addr)) ? fwd_data : rs1_data;
  assign rs2_val = (fwd_we && (fwd_rd != 5'd0) && (fwd_rd == rs2_addr)) ? fwd_data : rs2_data;
`else
  assign rs1_val = rs1_data;
  assign rs2_val = rs2_data;
`endif

  payload_t dec;

  always_comb begin
    dec      = '0;
    dec.ctrl = ALU_NOP;
    case (opcode)
      OPC_OP, OPC_OPIMM: begin
        dec.a = rs1_val;
        dec.b = (opcode == OPC_OP) ? rs2_val : imm;
        case (funct3)
          3'b000:  dec.ctrl = ((opcode == OPC_OP) && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b111:  dec.ctrl = ALU_AND;
          3'b110:  dec.ctrl = ALU_OR;
          3'b100:  dec.ctrl = ALU_XOR;
          3'b010:  dec.ctrl = ALU_SLT;
          3'b011:  dec.ctrl = ALU_SLTU;
          default: dec.illegal = 1'b1;
        endcase
      end
      OPC_LUI: begin
        dec.b    = imm;
        dec.ctrl = ALU_ADD;
      end
      OPC_AUIPC: begin
        dec.a    = pc;
        dec.b    = imm;
        dec.ctrl = ALU_ADD;
      end
      OPC_LOAD, OPC_STORE: begin
        dec.a    = rs1_val;
        dec.b    = imm;
        dec.ctrl = ALU_ADD;
      end
      OPC_JAL, OPC_JALR: begin
        dec.a    = pc;
        dec.b    = DATA_WIDTH'(4);
        dec.ctrl = ALU_ADD;
      end
      OPC_BRANCH: begin
        // Taken = (ALU result == 0) ^ br_inv.
        dec.a  = rs1_val;
        dec.b  = rs2_val;
        dec.br = 1'b1;
        case (funct3)
          3'b000: dec.ctrl = ALU_SUB;
          3'b001: begin dec.ctrl = ALU_SUB;  dec.br_inv = 1'b1; end
          3'b100: begin dec.ctrl = ALU_SLT;  dec.br_inv = 1'b1; end
          3'b101: begin dec.ctrl = ALU_SGE;  dec.br_inv = 1'b1; end
          3'b110: begin dec.ctrl = ALU_SLTU; dec.br_inv = 1'b1; end
          3'b111: dec.ctrl = ALU_SLTU;
          default: begin
            dec.br      = 1'b0;
            dec.illegal = 1'b1;
          end
        endcase
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  logic     out_vld_q, out_vld_d;
  logic     skid_vld_q, skid_vld_d;
  logic     in_rdy_q, in_rdy_d;
  payload_t out_q, out_d;
  payload_t skid_q, skid_d;
  logic     accept;
  logic     xfer;

  assign accept = in_valid && in_rdy_q;
  assign xfer   = out_vld_q && out_ready;

  always_comb begin
    out_vld_d  = out_vld_q;
    skid_vld_d = skid_vld_q;
    out_d      = out_q;
    skid_d     = skid_q;
    if (flush) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!out_vld_q || xfer) begin
      // in_ready mirrors an empty skid, so accept and a full skid never coincide.
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        out_d     = dec;
        out_vld_d = 1'b1;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (accept) begin
      skid_d     = dec;
      skid_vld_d = 1'b1;
    end
    in_rdy_d = !skid_vld_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      in_rdy_q   <= 1'b1;
      out_q      <= '0;
      skid_q     <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
      in_rdy_q   <= in_rdy_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
    end
  end

  assign in_ready  = in_rdy_q;
  assign out_valid = out_vld_q;
  assign alu_ctrl  = out_q.ctrl;
  assign alu_a     = out_q.a;
  assign alu_b     = out_q.b;
  assign br        = out_q.br;
  assign br_inv    = out_q.br_inv;
  assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vector table, then skid, flush and reset sequences.
module tb_alu_issue_stage;

  localparam logic [6:0] OP  = 7'b0110011;
  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] LUI = 7'b0110111;
  localparam logic [6:0] AUI = 7'b0010111;
  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] JLR = 7'b1100111;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] SYS = 7'b1110011;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic [31:0] rs1_data, rs2_data, imm, pc;
  logic        out_valid, out_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_a, alu_b;
  logic        br, br_inv, illegal;
`ifdef ALU_ISSUE_FORWARD_EN
  logic [4:0]  rs1_addr, rs2_addr, fwd_rd;
  logic        fwd_we;
  logic [31:0] fwd_data;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.DATA_WIDTH(32), .CTRL_BITS(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
    .br(br), .br_inv(br_inv), .illegal(illegal)
`ifdef ALU_ISSUE_FORWARD_EN
    , .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .fwd_we(fwd_we), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
`endif
  );

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] r1, r2, im, p;
    logic [3:0]  ctrl;
    logic [31:0] ea, eb;
    logic        ebr, einv, eill;
  } vec_t;

  vec_t vecs [0:23];

  function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                              input logic [31:0] r1, input logic [31:0] r2,
                              input logic [31:0] im, input logic [31:0] p,
                              input logic [3:0] c, input logic [31:0] ea, input logic [31:0] eb,
                              input logic ebr, input logic einv, input logic eill);
    vec_t v;
    v.op = op; v.f3 = f3; v.f7 = f7; v.r1 = r1; v.r2 = r2; v.im = im; v.p = p;
    v.ctrl = c; v.ea = ea; v.eb = eb; v.ebr = ebr; v.einv = einv; v.eill = eill;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_vec(input vec_t v);
    opcode = v.op; funct3 = v.f3; funct7b5 = v.f7;
    rs1_data = v.r1; rs2_data = v.r2; imm = v.im; pc = v.p;
  endtask

  // Simple ADD entry tagged through a and b.
  task automatic offer_add(input logic [31:0] tag);
    set_vec(mk(OP, 3'b000, 1'b0, tag, tag + 100, 32'h0, 32'h0, 4'h2, 0, 0, 0, 0, 0));
    in_valid = 1'b1;
  endtask

  initial begin
    vecs[0]  = mk(OP,  3'b000, 0, 75, 25, 0, 0,                      4'h2, 75, 25, 0, 0, 0);
    vecs[1]  = mk(OP,  3'b000, 1, 10, 3, 0, 0,                       4'h6, 10, 3, 0, 0, 0);
    vecs[2]  = mk(BR,  3'b001, 0, 1, 1, 8, 0,                        4'h6, 1, 1, 1, 1, 0);
    vecs[3]  = mk(OP,  3'b001, 0, 5, 6, 0, 0,                        4'h8, 5, 6, 0, 0, 1);
    vecs[4]  = mk(SYS, 3'b000, 0, 5, 6, 7, 0,                        4'h8, 0, 0, 0, 0, 1);
    vecs[5]  = mk(AUI, 3'b000, 0, 9, 0, 32'h2000, 32'h100,           4'h2, 32'h100, 32'h2000, 0, 0, 0);
    vecs[6]  = mk(LUI, 3'b000, 0, 7, 0, 32'h12345000, 0,             4'h2, 0, 32'h12345000, 0, 0, 0);
    vecs[7]  = mk(LD,  3'b010, 0, 32'h1000, 32'h55, 32'hFFFFFFFC, 0, 4'h2, 32'h1000, 32'hFFFFFFFC, 0, 0, 0);
    vecs[8]  = mk(ST,  3'b010, 0, 32'h2000, 32'h66, 32'h10, 0,       4'h2, 32'h2000, 32'h10, 0, 0, 0);
    vecs[9]  = mk(JAL, 3'b000, 0, 3, 0, 32'h800, 32'h40,             4'h2, 32'h40, 4, 0, 0, 0);
    vecs[10] = mk(JLR, 3'b000, 0, 32'h200, 0, 8, 32'h80,             4'h2, 32'h80, 4, 0, 0, 0);
    vecs[11] = mk(OPI, 3'b100, 0, 5, 9, 3, 0,                        4'h1, 5, 3, 0, 0, 0);
    vecs[12] = mk(OPI, 3'b000, 1, 20, 99, 32'hFFFFFFFF, 0,           4'h2, 20, 32'hFFFFFFFF, 0, 0, 0);
    vecs[13] = mk(OP,  3'b111, 0, 12, 10, 0, 0,                      4'h0, 12, 10, 0, 0, 0);
    vecs[14] = mk(OP,  3'b110, 0, 12, 10, 0, 0,                      4'h3, 12, 10, 0, 0, 0);
    vecs[15] = mk(OP,  3'b010, 0, 32'hFFFFFFFF, 1, 0, 0,             4'h7, 32'hFFFFFFFF, 1, 0, 0, 0);
    vecs[16] = mk(OPI, 3'b011, 0, 1, 77, 2, 0,                       4'hF, 1, 2, 0, 0, 0);
    vecs[17] = mk(BR,  3'b000, 0, 4, 4, 16, 0,                       4'h6, 4, 4, 1, 0, 0);
    vecs[18] = mk(BR,  3'b100, 0, 3, 8, 16, 0,                       4'h7, 3, 8, 1, 1, 0);
    vecs[19] = mk(BR,  3'b101, 0, 8, 3, 16, 0,                       4'h5, 8, 3, 1, 1, 0);
    vecs[20] = mk(BR,  3'b110, 0, 2, 9, 16, 0,                       4'hF, 2, 9, 1, 1, 0);
    vecs[21] = mk(BR,  3'b111, 0, 9, 2, 16, 0,                       4'hF, 9, 2, 1, 0, 0);
    vecs[22] = mk(BR,  3'b010, 0, 6, 7, 16, 0,                       4'h8, 6, 7, 0, 0, 1);
    vecs[23] = mk(OPI, 3'b101, 0, 6, 7, 2, 0,                        4'h8, 6, 2, 0, 0, 1);

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    opcode = '0; funct3 = '0; funct7b5 = 1'b0;
    rs1_data = '0; rs2_data = '0; imm = '0; pc = '0;
`ifdef ALU_ISSUE_FORWARD_EN
    rs1_addr = '0; rs2_addr = '0; fwd_we = 1'b0; fwd_rd = '0; fwd_data = '0;
`endif
    repeat (2) @(negedge clk);
    check("rst out_valid", 32'(out_valid), 0);
    check("rst in_ready", 32'(in_ready), 1);
    check("rst ctrl", 32'(alu_ctrl), 0);
    check("rst a", alu_a, 0);
    check("rst b", alu_b, 0);
    check("rst br", 32'(br), 0);
    check("rst br_inv", 32'(br_inv), 0);
    check("rst illegal", 32'(illegal), 0);
    rst = 1'b0;

    // Back-to-back decode table with the output always draining.
    for (int i = 0; i < 24; i++) begin
      set_vec(vecs[i]);
      in_valid = 1'b1;
      @(negedge clk);
      check($sformatf("v%0d out_valid", i), 32'(out_valid), 1);
      check($sformatf("v%0d ctrl", i), 32'(alu_ctrl), 32'(vecs[i].ctrl));
      check($sformatf("v%0d a", i), alu_a, vecs[i].ea);
      check($sformatf("v%0d b", i), alu_b, vecs[i].eb);
      check($sformatf("v%0d br", i), 32'(br), 32'(vecs[i].ebr));
      check($sformatf("v%0d br_inv", i), 32'(br_inv), 32'(vecs[i].einv));
      check($sformatf("v%0d illegal", i), 32'(illegal), 32'(vecs[i].eill));
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("drain out_valid", 32'(out_valid), 0);

    // Stall: two entries fill output + skid, third waits.
    out_ready = 1'b0;
    offer_add(1);
    @(negedge clk);
    check("bp e1 out_valid", 32'(out_valid), 1);
    check("bp e1 a", alu_a, 1);
    check("bp e1 in_ready", 32'(in_ready), 1);
    offer_add(2);
    @(negedge clk);
    check("bp after e2 in_ready", 32'(in_ready), 0);
    check("bp stall a", alu_a, 1);
    offer_add(3);
    @(negedge clk);
    check("bp hold in_ready", 32'(in_ready), 0);
    check("bp hold a", alu_a, 1);
    check("bp hold b", alu_b, 101);
    check("bp hold out_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp e2 a", alu_a, 2);
    check("bp e2 b", alu_b, 102);
    check("bp release in_ready", 32'(in_ready), 1);
    @(negedge clk);
    check("bp e3 a", alu_a, 3);
    check("bp e3 out_valid", 32'(out_valid), 1);
    in_valid = 1'b0;
    @(negedge clk);
    check("bp empty out_valid", 32'(out_valid), 0);

    // Flush with both entries buffered and a third offered.
    out_ready = 1'b0;
    offer_add(11);
    @(negedge clk);
    offer_add(12);
    @(negedge clk);
    check("fl full in_ready", 32'(in_ready), 0);
    offer_add(13);
    flush = 1'b1;
    @(negedge clk);
    check("fl out_valid", 32'(out_valid), 0);
    check("fl in_ready", 32'(in_ready), 1);
    offer_add(14);
    @(negedge clk);
    check("fl discard out_valid", 32'(out_valid), 0);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("fl quiet%0d out_valid", k), 32'(out_valid), 0);
    end

    // Reset mid-stream clears payload as well.
    out_ready = 1'b0;
    offer_add(32'h77);
    @(negedge clk);
    check("mr loaded out_valid", 32'(out_valid), 1);
    rst = 1'b1;
    offer_add(32'h78);
    @(negedge clk);
    check("mr out_valid", 32'(out_valid), 0);
    check("mr in_ready", 32'(in_ready), 1);
    check("mr ctrl", 32'(alu_ctrl), 0);
    check("mr a", alu_a, 0);
    check("mr b", alu_b, 0);
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);

`ifdef ALU_ISSUE_FORWARD_EN
    set_vec(mk(OP, 3'b000, 0, 32'h11, 32'h22, 32'h7, 0, 4'h2, 0, 0, 0, 0, 0));
    rs1_addr = 5; rs2_addr = 6; fwd_we = 1'b1; fwd_rd = 5; fwd_data = 32'hDEADBEEF;
    in_valid = 1'b1;
    @(negedge clk);
    check("fwd rs1 a", alu_a, 32'hDEADBEEF);
    check("fwd rs1 b", alu_b, 32'h22);
    rs1_addr = 0; fwd_rd = 0;
    @(negedge clk);
    check("fwd x0 a", alu_a, 32'h11);
    rs1_addr = 5; fwd_rd = 6;
    @(negedge clk);
    check("fwd rs2 a", alu_a, 32'h11);
    check("fwd rs2 b", alu_b, 32'hDEADBEEF);
    opcode = OPI;
    @(negedge clk);
    check("fwd opimm b", alu_b, 32'h7);
    in_valid = 1'b0; fwd_we = 1'b0;
    @(negedge clk);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
